// File: rtl/bk_prefix_pipe.sv
// rtl/bk_prefix_pipe.sv - three-stage elastic Brent-Kung carry prefix network
module bk_prefix_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   P,
  output logic [WIDTH:0]   G_PREFIX
);

  // Position 0 is the carry slot, so the prefix network spans WIDTH+1 positions.
  localparam int N = WIDTH + 1;
  localparam int L = $clog2(N);

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
    $error("bk_prefix_pipe: WIDTH must be a power of two >= 2");
  end

  logic         valid_1, valid_2, valid_3;
  logic         load_1, load_2, load_3;
  logic [N-1:0] p_1, g_1;
  logic [N-1:0] p_2, gu_2;
  logic [N-1:0] gu_nxt, gd_nxt;

  // Group propagate over the 'len' positions ending at 'hi' (range (hi-len, hi]).
  function automatic logic grp_p(input logic [N-1:0] p, input int hi, input int len);
    logic r;
    r = 1'b1;
    for (int t = 0; t < N; t++) begin
      if (t < len) begin
        r = r & p[hi-t];
      end
    end
    return r;
  endfunction

  // A stage may load when empty or when its successor drains this cycle.
  assign load_3    = !valid_3 || out_ready;
  assign load_2    = !valid_2 || load_3;
  assign load_1    = !valid_1 || load_2;
  assign in_ready  = load_1;
  assign out_valid = valid_3;

  // Up-sweep: combine pairs at doubling strides; nodes past the top position are pruned.
  always_comb begin
    gu_nxt = g_1;
    for (int l = 0; l < L; l++) begin
      for (int j = 0; j < N; j++) begin
        if ((j % (2 << l)) == ((2 << l) - 1)) begin
          gu_nxt[j] = gu_nxt[j] | (grp_p(p_1, j, 1 << l) & gu_nxt[j - (1 << l)]);
        end
      end
    end
  end

  // Down-sweep: fill the intermediate prefixes from already-complete ones.
  always_comb begin
    gd_nxt = gu_2;
    for (int l = L - 2; l >= 0; l--) begin
      for (int j = 0; j < N; j++) begin
        if (((j % (2 << l)) == ((1 << l) - 1)) && (j >= (2 << l))) begin
          gd_nxt[j] = gd_nxt[j] | (grp_p(p_2, j, 1 << l) & gd_nxt[j - (1 << l)]);
        end
      end
    end
  end

  // Valid bits advance through the pipe whenever the receiving stage loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_1 <= 1'b0;
      valid_2 <= 1'b0;
      valid_3 <= 1'b0;
    end else begin
      if (load_1) valid_1 <= in_valid;
      if (load_2) valid_2 <= valid_1;
      if (load_3) valid_3 <= valid_2;
    end
  end

  // Stage 1: per-position propagate and generate, carry-in in slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_1 <= '0;
      g_1 <= '0;
    end else if (in_valid && load_1) begin
      p_1 <= {A ^ B, 1'b0};
      g_1 <= {A & B, C_in};
    end
  end

  // Stage 2: register the up-sweep partial generates alongside the raw propagates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_2  <= '0;
      gu_2 <= '0;
    end else if (valid_1 && load_2) begin
      p_2  <= p_1;
      gu_2 <= gu_nxt;
    end
  end

  // Stage 3: completed prefixes and propagates drive the outputs straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      P        <= '0;
      G_PREFIX <= '0;
    end else if (valid_2 && load_3) begin
      P        <= p_2;
      G_PREFIX <= gd_nxt;
    end
  end

endmodule
